// File: rtl/sd_spi_master.sv
// SPI mode-0 byte engine: shifts one byte out on mosi (MSB first) while
// shifting one byte in from miso, at a slow or fast SCK rate chosen per byte.
module sd_spi_master #(
    parameter int SLOW_HALF_DIV = 125,
    parameter int FAST_HALF_DIV = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       speed_sel,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_out,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    localparam int MAX_DIV = (SLOW_HALF_DIV > FAST_HALF_DIV) ? SLOW_HALF_DIV : FAST_HALF_DIV;
    localparam int CW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam logic [CW-1:0] SLOW_M1 = CW'(SLOW_HALF_DIV - 1);
    localparam logic [CW-1:0] FAST_M1 = CW'(FAST_HALF_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCK_LO = 2'd1,
        SCK_HI = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [CW-1:0]   half_reg, half_next;
    logic [2:0]      bit_reg, bit_next;
    logic [7:0]      tx_reg, tx_next;
    logic [7:0]      rx_reg, rx_next;
    logic [7:0]      dout_reg, dout_next;
    logic            sck_reg, sck_next;
    logic            mosi_reg, mosi_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            half_reg  <= '0;
            bit_reg   <= '0;
            tx_reg    <= '0;
            rx_reg    <= '0;
            dout_reg  <= 8'h00;
            sck_reg   <= 1'b0;
            mosi_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            half_reg  <= half_next;
            bit_reg   <= bit_next;
            tx_reg    <= tx_next;
            rx_reg    <= rx_next;
            dout_reg  <= dout_next;
            sck_reg   <= sck_next;
            mosi_reg  <= mosi_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        half_next  = half_reg;
        bit_next   = bit_reg;
        tx_next    = tx_reg;
        rx_next    = rx_reg;
        dout_next  = dout_reg;
        sck_next   = sck_reg;
        mosi_next  = mosi_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                sck_next  = 1'b0;
                mosi_next = 1'b1;
                if (start) begin
                    half_next  = speed_sel ? FAST_M1 : SLOW_M1;
                    cnt_next   = speed_sel ? FAST_M1 : SLOW_M1;
                    tx_next    = data_in;
                    mosi_next  = data_in[7];
                    bit_next   = 3'd0;
                    busy_next  = 1'b1;
                    state_next = SCK_LO;
                end
            end
            SCK_LO: begin
                if (cnt_reg == '0) begin
                    sck_next   = 1'b1;
                    rx_next    = {rx_reg[6:0], miso};
                    cnt_next   = half_reg;
                    state_next = SCK_HI;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            SCK_HI: begin
                if (cnt_reg == '0) begin
                    sck_next = 1'b0;
                    cnt_next = half_reg;
                    if (bit_reg == 3'd7) begin
                        // rx_reg already holds all eight samples at this point
                        dout_next  = rx_reg;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                        mosi_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        bit_next   = bit_reg + 3'd1;
                        mosi_next  = tx_reg[6];
                        tx_next    = {tx_reg[6:0], 1'b0};
                        state_next = SCK_LO;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign data_out = dout_reg;
    assign sck      = sck_reg;
    assign mosi     = mosi_reg;

endmodule

// File: tb/tb_sd_spi_master.sv
// Bench for sd_spi_master: an SPI slave model plus per-byte timing and data
// expectations derived from the half-divider and the bytes exchanged.
module tb_sd_spi_master;

    localparam int SLOW = 4;
    localparam int FAST = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] data_in;
    logic       speed_sel;
    logic       busy;
    logic       done;
    logic [7:0] data_out;
    logic       sck;
    logic       mosi;
    logic       miso;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit start_pending = 1'b0;

    sd_spi_master #(.SLOW_HALF_DIV(SLOW), .FAST_HALF_DIV(FAST)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .data_in(data_in),
        .speed_sel(speed_sel), .busy(busy), .done(done), .data_out(data_out),
        .sck(sck), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Watch an idle bus for n cycles; report SCK/busy activity and done pulses.
    task automatic idle_watch(input int n, output bit active, output int dones);
        active = 1'b0;
        dones  = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sck !== 1'b0 || busy !== 1'b0 || mosi !== 1'b1) active = 1'b1;
            if (done === 1'b1) dones++;
        end
    endtask

    // One byte: slave returns rx MSB first, changing miso after each falling sck.
    // inj_at>0 pulses an extra start (data 8'h11) so it lands on edge inj_at.
    // chain=1 asserts start with the next byte in the done cycle.
    task automatic xfer(input string name, input logic [7:0] tx, input logic spd,
                        input logic [7:0] rx, input int inj_at, input bit chain,
                        input logic [7:0] ntx, input logic nspd, input logic [7:0] nrx,
                        output int st, output int dedge);
        int   h, nr, nf, budget;
        logic [7:0] bits;
        bit   psck, pmosi, timing_bad, busy_bad, got_done;
        h = spd ? FAST : SLOW;
        if (!start_pending) begin
            @(negedge clk);
            data_in = tx; speed_sel = spd; miso = rx[7]; start = 1'b1;
        end
        start_pending = 1'b0;
        @(negedge clk);
        start = 1'b0;
        st = cyc;
        nr = 0; nf = 0; bits = 8'h00; dedge = -1;
        timing_bad = 1'b0; busy_bad = 1'b0; got_done = 1'b0;
        psck = sck; pmosi = mosi;
        if (busy !== 1'b1) busy_bad = 1'b1;
        budget = 16 * SLOW + 40;
        for (int i = 0; i < budget && !got_done; i++) begin
            data_in   = 8'($urandom);
            speed_sel = ~spd;
            start     = (inj_at > 0 && cyc == st + inj_at - 1);
            if (start) data_in = 8'h11;
            @(negedge clk);
            if (sck === 1'b1 && psck == 1'b0) begin
                if (cyc - st != (2 * nr + 1) * h) timing_bad = 1'b1;
                if (nr < 8) bits[7 - nr] = mosi;
                nr++;
            end
            if (sck === 1'b0 && psck == 1'b1) begin
                if (cyc - st != (2 * nf + 2) * h) timing_bad = 1'b1;
                nf++;
                if (nf < 8) miso = rx[7 - nf];
            end else if (mosi !== pmosi) begin
                timing_bad = 1'b1;
            end
            psck = sck; pmosi = mosi;
            if (done === 1'b1) begin
                got_done = 1'b1;
                dedge = cyc;
            end else if (busy !== 1'b1) begin
                busy_bad = 1'b1;
            end
        end
        start = 1'b0;
        if (chain) begin
            data_in = ntx; speed_sel = nspd; miso = nrx[7]; start = 1'b1;
            start_pending = 1'b1;
        end
        n_checks++;
        if (!got_done) begin
            n_fail++; $display("FAIL %s done_timeout: got no done, required done within %0d cycles", name, budget);
        end
        n_checks++;
        if (bits !== tx || nr != 8) begin
            n_fail++; $display("FAIL %s mosi_bits: got %h (%0d rises), required %h (8 rises)", name, bits, nr, tx);
        end
        n_checks++;
        if (dedge - st != 16 * h) begin
            n_fail++; $display("FAIL %s done_latency: got %0d, required %0d", name, dedge - st, 16 * h);
        end
        n_checks++;
        if (data_out !== rx) begin
            n_fail++; $display("FAIL %s data_out: got %h, required %h", name, data_out, rx);
        end
        n_checks++;
        if (timing_bad) begin
            n_fail++; $display("FAIL %s sck_mosi_timing: got irregular edges, required half-period %0d", name, h);
        end
        n_checks++;
        if (busy_bad || busy !== 1'b0 || mosi !== 1'b1) begin
            n_fail++; $display("FAIL %s busy_mosi: got busy_gap=%0b busy_end=%b mosi_end=%b, required 0/0/1", name, busy_bad, busy, mosi);
        end
        $display("xfer %s tx=%h rx=%h H=%0d start=%0d done=%0d data_out=%h", name, tx, rx, h, st, dedge, data_out);
    endtask

    task automatic test_reset(input string name);
        bit act; int dn;
        @(negedge clk);
        data_in = 8'hC3; speed_sel = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({sck, mosi, busy, done, data_out} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL %s reset_outputs: got sck=%b mosi=%b busy=%b done=%b data_out=%h, required 0 1 0 0 00",
                     name, sck, mosi, busy, done, data_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle_watch(40, act, dn);
        n_checks++;
        if (act || dn != 0) begin
            n_fail++; $display("FAIL %s post_reset_idle: got activity=%0b dones=%0d, required 0 0", name, act, dn);
        end
        $display("reset %s data_out=%h busy=%b", name, data_out, busy);
    endtask

    task automatic test_fast_byte();
        int st, de;
        xfer("fast", 8'hA5, 1'b1, 8'h3C, 0, 1'b0, 8'h00, 1'b0, 8'h00, st, de);
    endtask

    task automatic test_slow_byte();
        int st, de;
        xfer("slow", 8'h00, 1'b0, 8'hFF, 0, 1'b0, 8'h00, 1'b0, 8'h00, st, de);
    endtask

    task automatic test_ignored_start();
        int st, de, dn; bit act;
        xfer("ignored", 8'hF0, 1'b1, 8'h5A, 10, 1'b0, 8'h00, 1'b0, 8'h00, st, de);
        idle_watch(40, act, dn);
        n_checks++;
        if (act || dn != 0) begin
            n_fail++; $display("FAIL ignored second_xfer: got activity=%0b extra_dones=%0d, required 0 0", act, dn);
        end
    endtask

    task automatic test_back_to_back();
        int st1, de1, st2, de2;
        xfer("b2b_1", 8'h12, 1'b1, 8'h81, 0, 1'b1, 8'h34, 1'b1, 8'h7E, st1, de1);
        xfer("b2b_2", 8'h34, 1'b1, 8'h7E, 0, 1'b0, 8'h00, 1'b0, 8'h00, st2, de2);
        n_checks++;
        if (st2 != de1 + 1 || de2 - de1 != 16 * FAST + 1) begin
            n_fail++; $display("FAIL b2b spacing: got accept_gap=%0d done_gap=%0d, required 1 %0d", st2 - de1, de2 - de1, 16 * FAST + 1);
        end
    endtask

    task automatic test_speed_switch();
        int st, de;
        // speed_sel is held inverted while each byte is in flight
        xfer("switch_slow", 8'hB7, 1'b0, 8'h29, 0, 1'b0, 8'h00, 1'b0, 8'h00, st, de);
        xfer("switch_fast", 8'h4C, 1'b1, 8'hD3, 0, 1'b0, 8'h00, 1'b0, 8'h00, st, de);
    endtask

    task automatic test_random();
        int st, de;
        for (int i = 0; i < 6; i++)
            xfer("random", 8'($urandom), 1'($urandom), 8'($urandom), 0, 1'b0, 8'h00, 1'b0, 8'h00, st, de);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; data_in = 8'h00; speed_sel = 1'b0; miso = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        test_reset("initial");
        test_fast_byte();
        test_slow_byte();
        test_ignored_start();
        test_back_to_back();
        test_speed_switch();
        test_random();
        test_fast_byte();
        test_reset("mid_byte");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
